// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer that sits after the register renamer.
// Instructions are allocated at the tail and marked done out of order.
// They retire in order from the head. Each retire produces a one-cycle
// {old_preg, has_dest} pulse that tells the renamer which old physical
// register it may free.

// One buffer slot: valid/done bookkeeping plus the displaced mapping.
module rob_entry #(
  parameter int PREG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_we,
  input  logic              complete_we,
  input  logic              retire_we,
  input  logic              alloc_dest,
  input  logic [PREG_W-1:0] alloc_old,
  output logic              valid,
  output logic              done,
  output logic              has_dest,
  output logic [PREG_W-1:0] old_preg
);

  // Status bits. A completion only lands on a live entry. Retire clearing
  // is written last so that it wins. Alloc and retire never target the
  // same slot in one cycle: that would require the buffer to be both
  // empty and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (alloc_we) begin
        valid <= 1'b1;
        done  <= 1'b0;
      end
      if (complete_we && valid) done <= 1'b1;
      if (retire_we) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_we) begin
      has_dest <= alloc_dest;
      old_preg <= alloc_old;
    end
  end

endmodule

module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int PREG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              alloc_valid,
  input  logic              alloc_has_dest,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  output logic [PREG_W:0]   retire_out,
  output logic              retire_pulse,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]             head, tail;
  logic [DEPTH-1:0]             ent_valid, ent_done, ent_dest;
  logic [DEPTH-1:0][PREG_W-1:0] ent_old;
  logic                         alloc_fire, retire_fire;

  assign alloc_ready = (count != FULL);
  assign alloc_tag   = tail;
  assign empty       = (count == '0);

  // alloc_ready deliberately ignores a same-cycle retire.
  assign alloc_fire  = ena && alloc_valid && alloc_ready;
  assign retire_fire = ena && ent_valid[head] && ent_done[head];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_entry #(.PREG_W(PREG_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .alloc_we    (alloc_fire && (tail == TAG_W'(i))),
      .complete_we (ena && complete_valid && (complete_tag == TAG_W'(i))),
      .retire_we   (retire_fire && (head == TAG_W'(i))),
      .alloc_dest  (alloc_has_dest),
      .alloc_old   (alloc_old_preg),
      .valid       (ent_valid[i]),
      .done        (ent_done[i]),
      .has_dest    (ent_dest[i]),
      .old_preg    (ent_old[i])
    );
  end

  // Pointers, occupancy and the registered retire port. Everything holds
  // while ena is low, so the frozen renamer neither loses nor repeats a
  // retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_out   <= '0;
      retire_pulse <= 1'b0;
    end else if (ena) begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (retire_fire) head <= head + 1'b1;
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      retire_pulse <= retire_fire;
      retire_out   <= retire_fire ? {ent_old[head], ent_dest[head]} : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer. A queue model of the buffer predicts the
// retire pulses and pushes them into a scoreboard. A separate monitor
// compares the DUT outputs after every edge against the model.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       alloc_valid = 1'b0;
  logic       alloc_has_dest = 1'b0;
  logic [3:0] alloc_old_preg = '0;
  logic       alloc_ready;
  logic [2:0] alloc_tag;
  logic       complete_valid = 1'b0;
  logic [2:0] complete_tag = '0;
  logic [4:0] retire_out;
  logic       retire_pulse;
  logic [3:0] count;
  logic       empty;

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .PREG_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest),
    .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .complete_valid(complete_valid),
    .complete_tag(complete_tag), .retire_out(retire_out),
    .retire_pulse(retire_pulse), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tag;
    logic       dest;
    logic [3:0] old;
    logic       done;
  } ent_t;

  ent_t       mq[$];       // in-flight instructions, oldest first
  logic [4:0] exp_q[$];    // scoreboard of expected retire words
  logic [2:0] m_next_tag = '0;
  bit         e_ena, e_rst;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model. It reads the inputs present at each edge and
  // decides from the pre-edge state whether the oldest instruction
  // retires.
  initial forever begin
    bit rf, room;
    @(posedge clk);
    e_ena = ena;
    e_rst = rst;
    if (rst) begin
      mq.delete();
      m_next_tag = '0;
    end else if (ena) begin
      rf   = (mq.size() > 0) && mq[0].done;
      room = mq.size() < 8;
      if (complete_valid)
        foreach (mq[i]) if (mq[i].tag == complete_tag) mq[i].done = 1'b1;
      if (rf) begin
        exp_q.push_back({mq[0].old, mq[0].dest});
        void'(mq.pop_front());
      end
      if (alloc_valid && room) begin
        mq.push_back('{m_next_tag, alloc_has_dest, alloc_old_preg, 1'b0});
        m_next_tag = m_next_tag + 3'd1;
      end
    end
  end

  // Monitor: runs just after each edge and checks the DUT against the model.
  initial begin
    logic [4:0] prev_out = '0;
    logic       prev_pulse = 1'b0;
    logic [4:0] w;
    forever begin
      @(posedge clk);
      #1;
      chk("count", int'(count), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("alloc_ready", int'(alloc_ready), int'(mq.size() < 8));
      chk("alloc_tag", int'(alloc_tag), int'(m_next_tag));
      if (e_rst) begin
        chk("reset_pulse", int'(retire_pulse), 0);
        chk("reset_out", int'(retire_out), 0);
      end else if (e_ena) begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("retire_pulse", int'(retire_pulse), 1);
          chk("retire_out", int'(retire_out), int'(w));
        end else begin
          chk("idle_pulse", int'(retire_pulse), 0);
          chk("idle_out", int'(retire_out), 0);
        end
      end else begin
        chk("frozen_pulse", int'(retire_pulse), int'(prev_pulse));
        chk("frozen_out", int'(retire_out), int'(prev_out));
      end
      prev_out   = retire_out;
      prev_pulse = retire_pulse;
    end
  end

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic cyc(input bit av, input bit hd, input logic [3:0] op,
                     input bit cv, input logic [2:0] ct,
                     input bit en = 1'b1, input bit rs = 1'b0);
    alloc_valid    = av;
    alloc_has_dest = hd;
    alloc_old_preg = op;
    complete_valid = cv;
    complete_tag   = ct;
    ena            = en;
    rst            = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 3'd0);
  endtask

  // Complete every outstanding instruction, oldest first, then let it drain.
  task automatic drain();
    for (int i = 0; i < 8; i++) cyc(0, 0, 4'd0, 1, 3'(i));
    idle(10);
  endtask

  initial begin
    logic [3:0] ops[3];
    ops[0] = 4'd5; ops[1] = 4'd6; ops[2] = 4'd9;

    // Reset, then idle for three cycles.
    cyc(0, 0, 4'd0, 0, 3'd0, 1, 1);
    cyc(0, 0, 4'd0, 0, 3'd0, 1, 1);
    idle(3);

    // Three allocations completed in reverse order retire in order.
    for (int i = 0; i < 3; i++) cyc(1, 1, ops[i], 0, 3'd0);
    cyc(0, 0, 4'd0, 1, 3'd2);
    cyc(0, 0, 4'd0, 1, 3'd1);
    cyc(0, 0, 4'd0, 1, 3'd0);
    idle(5);

    // Fill, stall while full, retire one, then allocate into the wrapped slot.
    cyc(0, 0, 4'd0, 0, 3'd0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 4'(i + 1), 0, 3'd0);
    cyc(1, 1, 4'hF, 0, 3'd0);
    cyc(1, 1, 4'hF, 0, 3'd0);
    cyc(1, 1, 4'hE, 1, 3'd0);
    cyc(1, 1, 4'hD, 0, 3'd0);
    cyc(1, 1, 4'hC, 0, 3'd0);
    drain();

    // A destination-less instruction still pulses, with bit 0 clear.
    cyc(1, 0, 4'd7, 0, 3'd0);
    cyc(0, 0, 4'd0, 1, m_next_tag - 3'd1);
    idle(3);

    // A completed head waits out four cycles with ena low.
    cyc(1, 1, 4'd3, 0, 3'd0);
    cyc(0, 0, 4'd0, 1, m_next_tag - 3'd1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 4'd2, 1, 3'd0, 0);
    idle(3);

    // A reset with five live entries discards them silently.
    cyc(0, 0, 4'd0, 0, 3'd0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 4'(i + 8), 0, 3'd0);
    cyc(0, 0, 4'd0, 1, 3'd1, 1, 1);
    cyc(0, 0, 4'd0, 1, 3'd2);
    idle(3);

    // Randomized traffic: frequent alloc/complete, occasional ena drops
    // and rare resets.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] ct;
      ct = 3'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 99) < 60)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      cyc($urandom_range(0, 99) < 60, 1'($urandom), 4'($urandom),
          $urandom_range(0, 99) < 55, ct,
          $urandom_range(0, 99) < 88, $urandom_range(0, 299) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer downstream of the register renamer.
- At rename, it takes one instruction per cycle along with the displaced physical mapping for that instruction's destination (the renamer's oldwrite).
- It collects out-of-order completion notices from execute.
- At in-order retirement, it emits a one-cycle pulse in the renamer's 5-bit retire format {preg, valid}. That pulse frees the old physical register in the renamer's claimed mask.

Parameters:
- DEPTH, 8, number of entries; power of two.
- TAG_W, 3, log2(DEPTH); width of entry tags, head and tail.
- PREG_W, 4, physical register index width; matches the renamer's 16 physical regs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  global advance enable, shared with the renamer; when low, all state and outputs hold.
- alloc_valid  input  1  rename stage presents an instruction this cycle.
- alloc_has_dest  input  1  instruction writes a register (the renamer's writein[0]).
- alloc_old_preg  input  PREG_W  displaced mapping (the renamer's oldwrite).
- alloc_ready  output  1  buffer can accept; combinational, equals (count != DEPTH).
- alloc_tag  output  TAG_W  tag assigned to the presented instruction; combinational, equals tail.
- complete_valid  input  1  execute reports completion.
- complete_tag  input  TAG_W  tag of the completed instruction.
- retire_out  output  PREG_W+1  registered {old_preg, has_dest}; connects to the renamer's retirein.
- retire_pulse  output  1  registered; high for one enabled cycle per retired instruction, including those without a destination.
- count  output  TAG_W+1  registered occupancy, 0..DEPTH.
- empty  output  1  combinational, equals (count == 0).

Behaviour:
- Per-entry state: valid, done, has_dest, old_preg.
- Pointers: head and tail are TAG_W-bit and wrap modulo DEPTH through natural overflow.
- Reset (rst high at a posedge, overrides everything including ena low):
  - head = tail = count = 0.
  - All valid and done bits cleared.
  - retire_out = 0, retire_pulse = 0.
  - As a result alloc_ready = 1, alloc_tag = 0, empty = 1.
  - Reset mid-operation discards all entries; no retire pulses are emitted for them.
- ena low: no allocation, completion or retirement takes place.
  - retire_out and retire_pulse hold their previous value. The renamer is also frozen, so no retire is lost or double-counted.
- Allocate fires at a posedge when ena && alloc_valid && alloc_ready:
  - entry[tail] <= {valid=1, done=0, has_dest, old_preg}.
  - tail <= tail+1.
  - alloc_valid while full is ignored; upstream must stall on alloc_ready.
- Complete fires at a posedge when ena && complete_valid:
  - If entry[complete_tag].valid, set done <= 1.
  - Completion of an invalid entry is ignored.
  - Completion of an already-done entry has no further effect.
- Retire fires at a posedge when ena && entry[head].valid && entry[head].done:
  - Clear entry[head].valid and entry[head].done.
  - head <= head+1.
  - retire_pulse <= 1.
  - retire_out <= {old_preg, has_dest}; a destination-less instruction yields retire_out[0] = 0.
  - If ena is high and no retire fires, retire_pulse <= 0 and retire_out <= 0.
  - At most one retire per cycle.
- Latency: the earliest retire edge is the edge after the one that set done. Example: complete at edge N, retire at edge N+1, retire_out visible after edge N+1.
- Simultaneous events:
  - Alloc and retire in the same cycle: count is unchanged; both pointers advance.
  - Full and retire in the same cycle: alloc_ready is still 0 that cycle. alloc_ready does not look ahead at retirement.
  - Complete targeting the head entry in the same cycle it is checked: done is set, and retirement happens the following edge.
  - Complete targeting the slot being allocated this cycle: ignored, because the entry is not valid before the edge.
- Count update: count <= count + alloc_fire - retire_fire. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then idle for 3 cycles -> count=0, empty=1, alloc_ready=1, alloc_tag=0, retire_out=0, retire_pulse=0.
- Allocate 3 instructions with old_preg 5, 6, 9 (all has_dest=1), then complete tags 2, 1, 0 on consecutive cycles -> no retirement until tag 0 completes. The next three edges then produce retire_out 0x0B, 0x0D, 0x13, in order, one per cycle; count returns to 0.
- Allocate 8 -> alloc_ready=0, count=8.
  - Hold alloc_valid=1 -> no allocation and tail unchanged.
  - Complete tag 0 -> one retire, alloc_ready=1.
  - The next allocation gets tag 0 (wrap-around).
- Allocate with has_dest=0, old_preg=7, then complete it -> retire_pulse=1, retire_out=0x0E (bit 0 clear, so the renamer frees nothing).
- Head complete, ena held low for 4 cycles -> no retire and outputs frozen. Raising ena -> retire fires on the first enabled edge.
- 5 entries live, rst asserted for one cycle -> count=0, all entries invalid. A later complete_tag=2 is ignored and no retire_pulse occurs.
